// File: rtl/bin2bcd_seg_seq.sv
// Sequential double-dabble binary-to-BCD converter (one bit per clock) with per-digit
// 7-segment decode, optional leading-zero blanking and saturation to all 9s on overflow.
module bin2bcd_seg_seq #(
  parameter int N_IN     = 14,
  parameter int N_DIG    = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_IN-1:0]    bin_in,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [4*N_DIG-1:0] bcd_out,
  output logic [7*N_DIG-1:0] seg_out
);

  localparam int SW = 4*N_DIG + N_IN;
  localparam int CW = $clog2(N_IN);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Largest value representable in N_DIG decimal digits; wider than any legal bin_in.
  localparam logic [63:0] MAX_VAL = pow10(N_DIG) - 64'd1;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [SW-1:0]        r_sr, w_adj;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf;
  logic                 w_ovf_in;
  logic [4*N_DIG-1:0]   w_bcd;
  logic [7*N_DIG-1:0]   w_seg;
  logic [N_DIG-1:0]     w_lz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == CW'(N_IN-1)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_ovf_in = (64'(bin_in) > MAX_VAL);

  // Add-3 correction on every BCD nibble, applied before the same-cycle shift.
  always_comb begin
    w_adj = r_sr;
    for (int k = 0; k < N_DIG; k++)
      if (r_sr[N_IN+4*k +: 4] >= 4'd5) w_adj[N_IN+4*k +: 4] = r_sr[N_IN+4*k +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_sr  <= {{(4*N_DIG){1'b0}}, bin_in};
          r_cnt <= '0;
          r_ovf <= w_ovf_in;
        end
        S_SHIFT: begin
          r_sr  <= {w_adj[SW-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_bcd = r_ovf ? {N_DIG{4'h9}} : r_sr[SW-1 -: 4*N_DIG];

  // w_lz[k]: digits k..N_DIG-1 are all zero.
  always_comb begin
    w_lz = '0;
    w_lz[N_DIG-1] = (w_bcd[4*(N_DIG-1) +: 4] == 4'd0);
    for (int k = N_DIG-2; k >= 0; k--)
      w_lz[k] = w_lz[k+1] & (w_bcd[4*k +: 4] == 4'd0);
  end

  for (genvar k = 0; k < N_DIG; k++) begin : g_seg
    if (BLANK_LZ != 0 && k > 0) begin : g_blank
      assign w_seg[7*k +: 7] = (!r_ovf && w_lz[k]) ? 7'h00 : seg7(w_bcd[4*k +: 4]);
    end else begin : g_show
      assign w_seg[7*k +: 7] = seg7(w_bcd[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
      seg_out  <= '0;
    end else begin
      done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        overflow <= r_ovf;
        bcd_out  <= w_bcd;
        seg_out  <= w_seg;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seg_seq.sv
// Bench for bin2bcd_seg_seq: four parameterisations share one clock; results are checked
// against a decimal reference computed with division/modulo and a segment lookup table.
module tb_bin2bcd_seg_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st [4];
  logic [31:0] bi [4];
  logic        dn [4];
  logic        bz [4];
  logic        ov [4];
  logic [63:0] bc [4];
  logic [63:0] sg [4];

  int nin [4] = '{14, 14, 8, 20};
  int ndg [4] = '{4, 4, 2, 6};
  int blk [4] = '{1, 0, 1, 1};

  logic [15:0] b0, b1;  logic [27:0] s0, s1;
  logic [7:0]  b2;      logic [13:0] s2;
  logic [23:0] b3;      logic [41:0] s3;
  logic d0, d1, d2, d3, y0, y1, y2, y3, o0, o1, o2, o3;

  bin2bcd_seg_seq #(.N_IN(14), .N_DIG(4), .BLANK_LZ(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .bin_in(bi[0][13:0]),
    .busy(y0), .done(d0), .overflow(o0), .bcd_out(b0), .seg_out(s0));
  bin2bcd_seg_seq #(.N_IN(14), .N_DIG(4), .BLANK_LZ(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .bin_in(bi[1][13:0]),
    .busy(y1), .done(d1), .overflow(o1), .bcd_out(b1), .seg_out(s1));
  bin2bcd_seg_seq #(.N_IN(8), .N_DIG(2), .BLANK_LZ(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .bin_in(bi[2][7:0]),
    .busy(y2), .done(d2), .overflow(o2), .bcd_out(b2), .seg_out(s2));
  bin2bcd_seg_seq #(.N_IN(20), .N_DIG(6), .BLANK_LZ(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .bin_in(bi[3][19:0]),
    .busy(y3), .done(d3), .overflow(o3), .bcd_out(b3), .seg_out(s3));

  assign dn[0] = d0; assign dn[1] = d1; assign dn[2] = d2; assign dn[3] = d3;
  assign bz[0] = y0; assign bz[1] = y1; assign bz[2] = y2; assign bz[3] = y3;
  assign ov[0] = o0; assign ov[1] = o1; assign ov[2] = o2; assign ov[3] = o3;
  assign bc[0] = 64'(b0); assign bc[1] = 64'(b1); assign bc[2] = 64'(b2); assign bc[3] = 64'(b3);
  assign sg[0] = 64'(s0); assign sg[1] = 64'(s1); assign sg[2] = 64'(s2); assign sg[3] = 64'(s3);

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int ncmp = 0;
  int nfail = 0;

  function automatic logic [63:0] p10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic ref_ovf(input logic [63:0] v, input int nd);
    return v > p10(nd) - 64'd1;
  endfunction

  function automatic logic [63:0] ref_bcd(input logic [63:0] v, input int nd);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < nd; k++)
      r[4*k +: 4] = ref_ovf(v, nd) ? 4'd9 : 4'((v / p10(k)) % 64'd10);
    return r;
  endfunction

  function automatic logic [63:0] ref_seg(input logic [63:0] v, input int nd, input int bl);
    logic [63:0] r;
    logic [63:0] b;
    r = '0;
    b = ref_bcd(v, nd);
    for (int k = 0; k < nd; k++)
      if (!ref_ovf(v, nd) && bl != 0 && k > 0 && v < p10(k)) r[7*k +: 7] = 7'h00;
      else r[7*k +: 7] = segtab[b[4*k +: 4]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full conversion on instance id; checks latency, busy length and all results.
  task automatic conv(input int id, input logic [31:0] v, input string tag);
    int lat;
    int nb;
    @(posedge clk); #1;
    bi[id] = v;
    st[id] = 1'b1;
    @(posedge clk); #1;
    st[id] = 1'b0;
    bi[id] = $urandom;
    nb = int'(bz[id]);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (dn[id]) begin lat = c; break; end
      nb += int'(bz[id]);
    end
    check({tag, "_lat"},  64'(lat), 64'(nin[id] + 1));
    check({tag, "_busy"}, 64'(nb),  64'(nin[id]));
    check({tag, "_bcd"},  bc[id], ref_bcd(64'(v), ndg[id]));
    check({tag, "_seg"},  sg[id], ref_seg(64'(v), ndg[id], blk[id]));
    check({tag, "_ovf"},  64'(ov[id]), 64'(ref_ovf(64'(v), ndg[id])));
  endtask

  initial begin
    logic [31:0] vals [65];
    int nd_seen;
    for (int i = 0; i < 4; i++) begin st[i] = 1'b0; bi[i] = '0; end

    // Reset state
    #23;
    check("rst_bcd",  bc[0], 64'd0);
    check("rst_seg",  sg[0], 64'd0);
    check("rst_ovf",  64'(ov[0]), 64'd0);
    check("rst_busy", 64'(bz[0]), 64'd0);
    check("rst_done", 64'(dn[0]), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed values
    conv(0, 32'd1234, "v1234");
    check("v1234_const_bcd", bc[0], 64'h1234);
    check("v1234_const_seg", sg[0], 64'({7'h06, 7'h5B, 7'h4F, 7'h66}));
    conv(0, 32'd0, "zero_blank");
    check("zero_blank_const_seg", sg[0], 64'h3F);
    conv(1, 32'd0, "zero_noblank");
    check("zero_noblank_const_seg", sg[1], 64'({7'h3F, 7'h3F, 7'h3F, 7'h3F}));
    conv(0, 32'd9999, "v9999");
    conv(0, 32'd10000, "v10000");
    check("v10000_const_seg", sg[0], 64'({7'h6F, 7'h6F, 7'h6F, 7'h6F}));
    check("v10000_const_ovf", 64'(ov[0]), 64'd1);
    conv(0, 32'd5, "v5");
    check("v5_const_seg", sg[0], 64'h6D);
    conv(0, 32'd16383, "vmax");
    conv(1, 32'd405, "noblank_405");

    // Async reset in the middle of a conversion
    conv(0, 32'd4321, "pre_rst");
    @(posedge clk); #1;
    bi[0] = 32'd777; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bz[0]), 64'd0);
    check("midrst_bcd",  bc[0], 64'd0);
    check("midrst_seg",  sg[0], 64'd0);
    @(negedge clk); rst_n = 1'b1;
    nd_seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      nd_seen += int'(dn[0]);
    end
    check("midrst_no_done", 64'(nd_seen), 64'd0);

    // start held high, bin_in changing every cycle
    for (int i = 0; i < 65; i++) vals[i] = 32'($urandom_range(0, 16383));
    @(posedge clk); #1;
    bi[0] = vals[0]; st[0] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      bi[0] = vals[i+1];
      check("hold_done", 64'(dn[0]), 64'((i % 16) == 15));
      if ((i % 16) == 15) begin
        check("hold_bcd", bc[0], ref_bcd(64'(vals[i-15]), 4));
        check("hold_ovf", 64'(ov[0]), 64'(ref_ovf(64'(vals[i-15]), 4)));
      end
    end
    st[0] = 1'b0;

    // Random sweeps and per-build boundaries
    for (int i = 0; i < 16; i++) conv(0, 32'($urandom_range(0, 16383)), "rnd14");
    conv(2, 32'd99, "n8_99");
    conv(2, 32'd100, "n8_100");
    conv(2, 32'd255, "n8_255");
    for (int i = 0; i < 8; i++) conv(2, 32'($urandom_range(0, 255)), "rnd8");
    conv(3, 32'd999999, "n20_999999");
    conv(3, 32'd1000000, "n20_1000000");
    conv(3, 32'd7, "n20_7");
    for (int i = 0; i < 8; i++) conv(3, 32'($urandom_range(0, 1048575)), "rnd20");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
